// File: rtl/vga_pkg.sv
// Shared VGA-domain types and raster constants for the frame-buffer load path.
package vga_pkg;

  localparam int unsigned HVID_DEF = 640;
  localparam int unsigned VVID_DEF = 480;

  typedef struct packed {
    logic [7:0] r;
    logic [7:0] g;
    logic [7:0] b;
  } pixel_t;

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    DONE
  } ld_state_e;

endpackage

// File: rtl/raster_addr_counter.sv
// Raster x/y position plus running linear address; advances one pixel per
// advance pulse and wraps to 0 after the last pixel of the frame.
module raster_addr_counter
  import vga_pkg::*;
#(
  parameter int unsigned HVID   = HVID_DEF,
  parameter int unsigned VVID   = VVID_DEF,
  parameter int unsigned ADDR_W = $clog2(HVID * VVID)
) (
  input  logic              clk_25,
  input  logic              rst,
  input  logic              clear,
  input  logic              advance,
  output logic [ADDR_W-1:0] addr,
  output logic              last_pixel
);

  localparam int unsigned XW = (HVID > 1) ? $clog2(HVID) : 1;
  localparam int unsigned YW = (VVID > 1) ? $clog2(VVID) : 1;
  localparam logic [XW-1:0] X_LAST = XW'(HVID - 1);
  localparam logic [YW-1:0] Y_LAST = YW'(VVID - 1);

  logic [XW-1:0]     x_q, x_d;
  logic [YW-1:0]     y_q, y_d;
  logic [ADDR_W-1:0] addr_q, addr_d;

  assign last_pixel = (x_q == X_LAST) && (y_q == Y_LAST);
  assign addr       = addr_q;

  // Linear address is a plain running count, so no y*HVID multiplier is needed.
  always_comb begin
    x_d    = x_q;
    y_d    = y_q;
    addr_d = addr_q;
    if (clear) begin
      x_d    = '0;
      y_d    = '0;
      addr_d = '0;
    end else if (advance) begin
      if (x_q == X_LAST) begin
        x_d = '0;
        y_d = (y_q == Y_LAST) ? '0 : y_q + YW'(1);
      end else begin
        x_d = x_q + XW'(1);
      end
      addr_d = last_pixel ? '0 : addr_q + ADDR_W'(1);
    end
  end

  always_ff @(posedge clk_25) begin
    if (rst) begin
      x_q    <= '0;
      y_q    <= '0;
      addr_q <= '0;
    end else begin
      x_q    <= x_d;
      y_q    <= y_d;
      addr_q <= addr_d;
    end
  end

endmodule

// File: rtl/image_load_controller.sv
// Full-frame image loader: pixel handshake in, raster-addressed frame-buffer
// writes out. Optional build macro IMAGE_LOAD_CHECKSUM_EN adds an XOR checksum port.
module image_load_controller
  import vga_pkg::*;
#(
  parameter int unsigned HVID   = HVID_DEF,
  parameter int unsigned VVID   = VVID_DEF,
  parameter int unsigned ADDR_W = $clog2(HVID * VVID)
) (
  input  logic              clk_25,
  input  logic              rst,
  input  logic              start,
  input  logic              abort,
  input  logic              s_valid,
  input  logic [23:0]       s_data,
  output logic              s_ready,
  output logic              load_enable,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [23:0]       wr_data,
  output logic              busy,
  output logic              done
`ifdef IMAGE_LOAD_CHECKSUM_EN
  ,
  output logic [23:0]       checksum
`endif
);

  ld_state_e         state_q, state_d;
  logic              wr_en_q, wr_en_d;
  logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
  pixel_t            wr_data_q, wr_data_d;
  logic [ADDR_W-1:0] addr;
  logic              last_pixel;
  logic              accept;
  logic              load_start;

  assign s_ready    = (state_q == LOAD) && !abort;
  assign accept     = s_valid && s_ready;
  assign load_start = start && (state_q != LOAD);

  raster_addr_counter #(
    .HVID  (HVID),
    .VVID  (VVID),
    .ADDR_W(ADDR_W)
  ) u_raster (
    .clk_25    (clk_25),
    .rst       (rst),
    .clear     (load_start),
    .advance   (accept),
    .addr      (addr),
    .last_pixel(last_pixel)
  );

  always_comb begin
    state_d   = state_q;
    wr_en_d   = accept;
    wr_addr_d = accept ? addr : wr_addr_q;
    wr_data_d = accept ? pixel_t'(s_data) : wr_data_q;
    unique case (state_q)
      IDLE:    if (start) state_d = LOAD;
      LOAD:    if (abort) state_d = IDLE;
               else if (accept && last_pixel) state_d = DONE;
      DONE:    if (start) state_d = LOAD;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_25) begin
    if (rst) begin
      state_q   <= IDLE;
      wr_en_q   <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
    end else begin
      state_q   <= state_d;
      wr_en_q   <= wr_en_d;
      wr_addr_q <= wr_addr_d;
      wr_data_q <= wr_data_d;
    end
  end

  assign load_enable = (state_q == LOAD);
  assign busy        = (state_q == LOAD);
  assign done        = (state_q == DONE);
  assign wr_en       = wr_en_q;
  assign wr_addr     = wr_addr_q;
  assign wr_data     = wr_data_q;

`ifdef IMAGE_LOAD_CHECKSUM_EN
  logic [23:0] checksum_q, checksum_d;

  always_comb begin
    checksum_d = checksum_q;
    if (load_start)  checksum_d = '0;
    else if (accept) checksum_d = checksum_q ^ s_data;
  end

  always_ff @(posedge clk_25) begin
    if (rst) checksum_q <= '0;
    else     checksum_q <= checksum_d;
  end

  assign checksum = checksum_q;
`endif

endmodule

// File: tb/tb_image_load_controller.sv
// Directed bench for image_load_controller on a 4x2 raster; checksum cases
// are compiled in only with IMAGE_LOAD_CHECKSUM_EN.
module tb_image_load_controller;

  logic        clk_25 = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic        abort = 1'b0;
  logic        s_valid = 1'b0;
  logic [23:0] s_data = '0;
  logic        s_ready, load_enable, wr_en, busy, done;
  logic [2:0]  wr_addr;
  logic [23:0] wr_data;
`ifdef IMAGE_LOAD_CHECKSUM_EN
  logic [23:0] checksum;
`endif

  int unsigned n_checks = 0;
  int unsigned n_pass = 0;

  always #20 clk_25 = ~clk_25;

  image_load_controller #(
    .HVID(4),
    .VVID(2)
  ) dut (
    .clk_25     (clk_25),
    .rst        (rst),
    .start      (start),
    .abort      (abort),
    .s_valid    (s_valid),
    .s_data     (s_data),
    .s_ready    (s_ready),
    .load_enable(load_enable),
    .wr_en      (wr_en),
    .wr_addr    (wr_addr),
    .wr_data    (wr_data),
    .busy       (busy),
    .done       (done)
`ifdef IMAGE_LOAD_CHECKSUM_EN
    ,
    .checksum   (checksum)
`endif
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk_25);
    #1;
  endtask

  task automatic do_start();
    start = 1'b1;
    tick();
    start = 1'b0;
    check("start_busy", 32'(busy), 32'd1);
    check("start_no_wr", 32'(wr_en), 32'd0);
  endtask

  // One accepted pixel; the write must appear right after the edge.
  task automatic push(input logic [23:0] d, input int unsigned exp_addr);
    s_valid = 1'b1;
    s_data  = d;
    #1;
    check("push_ready", 32'(s_ready), 32'd1);
    tick();
    s_valid = 1'b0;
    check("push_wr_en", 32'(wr_en), 32'd1);
    check("push_wr_addr", 32'(wr_addr), exp_addr);
    check("push_wr_data", 32'(wr_data), 32'(d));
  endtask

  task automatic expect_done();
    check("done", 32'(done), 32'd1);
    check("done_load_en", 32'(load_enable), 32'd0);
    check("done_busy", 32'(busy), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    // Reset state
    tick();
    tick();
    check("rst_wr_en", 32'(wr_en), 32'd0);
    check("rst_wr_addr", 32'(wr_addr), 32'd0);
    check("rst_wr_data", 32'(wr_data), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_load_en", 32'(load_enable), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_s_ready", 32'(s_ready), 32'd0);
    rst = 1'b0;
    tick();

    // 1: back-to-back frame
    do_start();
    for (int i = 0; i < 7; i++) begin
      push(24'(i + 1), i);
      check("t1_busy", 32'(busy), 32'd1);
    end
    push(24'h000008, 7);
    expect_done();
    tick();
    check("t1_wr_idle", 32'(wr_en), 32'd0);
    check("t1_addr_hold", 32'(wr_addr), 32'd7);
    check("t1_data_hold", 32'(wr_data), 32'h000008);
    check("t1_done_hold", 32'(done), 32'd1);

    // 2: source stalls between accepts
    do_start();
    for (int k = 0; k < 8; k++) begin
      push(24'h000100 + 24'(k), k);
      if (k < 7) begin
        tick();
        check("t2_gap1_wr", 32'(wr_en), 32'd0);
        check("t2_gap_addr", 32'(wr_addr), k);
        tick();
        check("t2_gap2_wr", 32'(wr_en), 32'd0);
      end
    end
    expect_done();

    // 3: abort on the third accept cycle, then restart
    do_start();
    push(24'h000021, 0);
    push(24'h000022, 1);
    s_valid = 1'b1;
    abort   = 1'b1;
    s_data  = 24'h000023;
    #1;
    check("t3_abort_ready", 32'(s_ready), 32'd0);
    tick();
    abort   = 1'b0;
    s_valid = 1'b0;
    check("t3_abort_wr", 32'(wr_en), 32'd0);
    check("t3_abort_addr", 32'(wr_addr), 32'd1);
    check("t3_abort_data", 32'(wr_data), 32'h000022);
    check("t3_abort_busy", 32'(busy), 32'd0);
    check("t3_abort_done", 32'(done), 32'd0);
    s_valid = 1'b1;
    #1;
    check("t3_idle_ready", 32'(s_ready), 32'd0);
    tick();
    s_valid = 1'b0;
    check("t3_idle_wr", 32'(wr_en), 32'd0);
    do_start();
    push(24'h000031, 0);

    // 4: start during LOAD is ignored
    push(24'h000032, 1);
    start = 1'b1;
    push(24'h000033, 2);
    start = 1'b0;
    check("t4_busy", 32'(busy), 32'd1);
    for (int k = 3; k < 8; k++) push(24'h000031 + 24'(k), k);
    expect_done();

    // 5: reset mid-line at x=2
    do_start();
    push(24'h000041, 0);
    push(24'h000042, 1);
    rst     = 1'b1;
    s_valid = 1'b1;
    s_data  = 24'h000043;
    tick();
    rst     = 1'b0;
    s_valid = 1'b0;
    check("t5_wr_en", 32'(wr_en), 32'd0);
    check("t5_wr_addr", 32'(wr_addr), 32'd0);
    check("t5_wr_data", 32'(wr_data), 32'd0);
    check("t5_busy", 32'(busy), 32'd0);
    check("t5_load_en", 32'(load_enable), 32'd0);
    check("t5_done", 32'(done), 32'd0);
    check("t5_s_ready", 32'(s_ready), 32'd0);
    do_start();
    push(24'h000051, 0);

`ifdef IMAGE_LOAD_CHECKSUM_EN
    // 6: checksum over a frame (restart from LOAD goes via abort)
    abort = 1'b1;
    tick();
    abort = 1'b0;
    do_start();
    check("t6_cks_clear", 32'(checksum), 32'd0);
    push(24'hFF0000, 0);
    push(24'h00FF00, 1);
    push(24'h0000FF, 2);
    push(24'hFFFFFF, 3);
    for (int k = 4; k < 8; k++) push(24'h000000, k);
    expect_done();
    check("t6_cks_zero", 32'(checksum), 32'h000000);
    do_start();
    push(24'h123456, 0);
    push(24'h00FF00, 1);
    push(24'h0000FF, 2);
    push(24'hFFFFFF, 3);
    for (int k = 4; k < 8; k++) push(24'h000000, k);
    expect_done();
    check("t6_cks_mixed", 32'(checksum), 32'hED3456);
    tick();
    check("t6_cks_hold", 32'(checksum), 32'hED3456);
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
